// File: rtl/aurora_fifo_packer_pkg.sv
// Shared types and constants for the Aurora RX to native-FIFO packer.
package aurora_fifo_pkg;

  localparam int unsigned DROP_CNT_W  = 16;
  localparam int unsigned BEAT_DATA_W = 64;

  // Beat as held in the skid buffer. This is the default-width layout;
  // the packer declares the same shape at its own IN_WIDTH.
  typedef struct packed {
    logic                   last;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  // Width of a lane index. A single-lane word still gets a 1-bit counter.
  function automatic int unsigned lane_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/aurora_fifo_packer_if.sv
// Aurora RX stream in, native FIFO write port out, plus overflow status.
interface aurora_fifo_packer_if
  import aurora_fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 64,
  parameter int unsigned RATIO    = 4
) ();

  logic                      m_axis_tvalid;
  logic [IN_WIDTH-1:0]       m_axis_tdata;
  logic                      m_axis_tlast;
  logic                      fifo_full;
  logic                      wr_en;
  logic [IN_WIDTH*RATIO-1:0] data_in;
  logic [RATIO-1:0]          data_keep;
  logic                      data_last;
  logic                      overflow;
  logic                      overflow_clr;
  logic [DROP_CNT_W-1:0]     drop_cnt;

  // Stream source and FIFO side.
  modport master (
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_full, overflow_clr,
    input  wr_en, data_in, data_keep, data_last, overflow, drop_cnt
  );

  // Packer side.
  modport slave (
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_full, overflow_clr,
    output wr_en, data_in, data_keep, data_last, overflow, drop_cnt
  );

endinterface

// File: rtl/aurora_rx_skid_buf.sv
// Circular skid buffer. Pointers carry a wrap bit: equal index with differing
// wrap bits means full. The caller only pushes when there is room (or a pop
// frees the head in the same cycle) and only pops when non-empty.
module aurora_rx_skid_buf
  import aurora_fifo_pkg::*;
#(
  parameter type         entry_t = beat_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_data,
  output logic   o_full,
  output logic   o_empty,
  output entry_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  entry_t      r_mem [DEPTH];

  // Pointer advance on push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/aurora_fifo_packer.sv
// Packs RATIO Aurora RX beats into one native-FIFO word, closing early on
// tlast. A skid buffer absorbs FIFO back-pressure; beats arriving while it is
// full are dropped and counted.
module aurora_fifo_packer
  import aurora_fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aurora_fifo_packer_if.slave  bus
);

  localparam int unsigned LANE_W = lane_w(RATIO);
  localparam int unsigned WORD_W = IN_WIDTH * RATIO;

  typedef struct packed {
    logic                last;
    logic [IN_WIDTH-1:0] data;
  } beat_w_t;

  beat_w_t w_in_beat;
  beat_w_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_completes;
  logic    w_pop;
  logic    w_push;
  logic    w_drop;

  logic [WORD_W-1:0]     w_asm_next;
  logic [RATIO-1:0]      w_keep_next;

  logic [LANE_W-1:0]     r_lane;
  logic [WORD_W-1:0]     r_asm;
  logic [RATIO-1:0]      r_keep;
  logic                  r_wr_en;
  logic [WORD_W-1:0]     r_data_in;
  logic [RATIO-1:0]      r_data_keep;
  logic                  r_data_last;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign w_in_beat = '{last: bus.m_axis_tlast, data: bus.m_axis_tdata};

  // Only a word-completing head beat needs FIFO room; partial lanes always drain.
  assign w_completes = (r_lane == LANE_W'(RATIO - 1)) || w_head.last;
  assign w_pop       = !w_empty && (!w_completes || !bus.fifo_full);
  assign w_push      = !rst && bus.m_axis_tvalid && (!w_full || w_pop);
  assign w_drop      = !rst && bus.m_axis_tvalid && w_full && !w_pop;

  aurora_rx_skid_buf #(
    .entry_t (beat_w_t),
    .DEPTH   (BUF_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in_beat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Assembly register with the head beat merged into the current lane.
  always_comb begin
    w_asm_next  = r_asm;
    w_keep_next = r_keep;
    w_asm_next[r_lane*IN_WIDTH +: IN_WIDTH] = w_head.data;
    w_keep_next[r_lane]                     = 1'b1;
  end

  // Lane packing and the registered FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane      <= '0;
      r_asm       <= '0;
      r_keep      <= '0;
      r_wr_en     <= 1'b0;
      r_data_in   <= '0;
      r_data_keep <= '0;
      r_data_last <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_pop) begin
        if (w_completes) begin
          r_data_in   <= w_asm_next;
          r_data_keep <= w_keep_next;
          r_data_last <= w_head.last;
          r_wr_en     <= 1'b1;
          r_asm       <= '0;
          r_keep      <= '0;
          r_lane      <= '0;
        end else begin
          r_asm  <= w_asm_next;
          r_keep <= w_keep_next;
          r_lane <= r_lane + 1'b1;
        end
      end
    end
  end

  // Sticky overflow (set beats clear) and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.overflow_clr) r_overflow <= 1'b0;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.data_in   = r_data_in;
  assign bus.data_keep = r_data_keep;
  assign bus.data_last = r_data_last;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_aurora_fifo_packer.sv
// Directed bench for aurora_fifo_packer with a scoreboard of expected words.
module tb_aurora_fifo_packer;
  import aurora_fifo_pkg::*;

  localparam int unsigned W = 64;
  localparam int unsigned R = 4;

  typedef struct {
    logic [W*R-1:0] d;
    logic [R-1:0]   k;
    logic           l;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   base;
  word_t exp_q[$];
  int    wr_log[$];

  always #5 clk = ~clk;

  aurora_fifo_packer_if #(.IN_WIDTH(W), .RATIO(R)) bus ();

  aurora_fifo_packer #(.IN_WIDTH(W), .RATIO(R), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [W*R-1:0] obs, input logic [W*R-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*R-1:0] mkword(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                            input logic [W-1:0] b2, input logic [W-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic expect_word(input logic [W*R-1:0] d, input logic [R-1:0] k, input logic l);
    word_t e;
    e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, sample after the edge, score any FIFO write.
  task automatic tick();
    word_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_en === 1'b1) begin
      wr_log.push_back(cyc);
      chk("wr_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_in",   bus.data_in,   e.d);
        chk("data_keep", bus.data_keep, e.k);
        chk("data_last", bus.data_last, e.l);
      end
    end
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l);
    bus.m_axis_tvalid = 1'b1;
    bus.m_axis_tdata  = d;
    bus.m_axis_tlast  = l;
    tick();
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"},     bus.wr_en,     0);
    chk({tag, "_data_in"},   bus.data_in,   0);
    chk({tag, "_data_keep"}, bus.data_keep, 0);
    chk({tag, "_data_last"}, bus.data_last, 0);
    chk({tag, "_overflow"},  bus.overflow,  0);
    chk({tag, "_drop_cnt"},  bus.drop_cnt,  0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tlast  = 1'b0;
    bus.fifo_full     = 1'b0;
    bus.overflow_clr  = 1'b0;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;
    idle(1);

    // Continuous full words: writes at cycles 5 and 9 after the first beat.
    wr_log.delete();
    base = cyc;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) expect_word(mkword(64'h1, 64'h2, 64'h3, 64'h4), 4'hF, 1'b0);
      if (i == 8) expect_word(mkword(64'h5, 64'h6, 64'h7, 64'h8), 4'hF, 1'b1);
      beat(W'(i), (i == 8));
    end
    idle(4);
    chk("cont_nwr", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      chk("cont_t0", wr_log[0] - base, 5);
      chk("cont_t1", wr_log[1] - base, 9);
    end

    // Short frame closed by tlast.
    expect_word(mkword(64'hA, 64'hB, 64'h0, 64'h0), 4'h3, 1'b1);
    beat(64'hA, 1'b0);
    beat(64'hB, 1'b1);
    idle(4);

    // Back-pressure: completing beat stalls until fifo_full drops.
    wr_log.delete();
    base = cyc;
    beat(64'h21, 1'b0);
    beat(64'h22, 1'b0);
    bus.fifo_full = 1'b1;
    beat(64'h23, 1'b0);
    chk("bp_hold0", bus.wr_en, 0);
    expect_word(mkword(64'h21, 64'h22, 64'h23, 64'h24), 4'hF, 1'b0);
    beat(64'h24, 1'b0);
    chk("bp_hold1", bus.wr_en, 0);
    idle(1);
    chk("bp_hold2", bus.wr_en, 0);
    bus.fifo_full = 1'b0;
    idle(4);
    chk("bp_nwr", wr_log.size(), 1);
    if (wr_log.size() >= 1) chk("bp_t", wr_log[0] - base, 6);
    chk("bp_drop", bus.drop_cnt, 0);
    chk("bp_ovf",  bus.overflow, 0);

    // Overflow: 3 drain, 4 buffer, 5 dropped.
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 12; i++) beat(W'(32'h51 + i), 1'b0);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_cnt",  bus.drop_cnt, 5);
    bus.overflow_clr = 1'b1;
    idle(1);
    bus.overflow_clr = 1'b0;
    idle(1);
    chk("ovf_clr_flag", bus.overflow, 0);
    chk("ovf_clr_cnt",  bus.drop_cnt, 5);
    expect_word(mkword(64'h51, 64'h52, 64'h53, 64'h54), 4'hF, 1'b0);
    bus.fifo_full = 1'b0;
    idle(4);
    expect_word(mkword(64'h55, 64'h56, 64'h57, 64'h5D), 4'hF, 1'b1);
    beat(64'h5D, 1'b1);
    idle(4);
    chk("ovf_post_cnt",  bus.drop_cnt, 5);
    chk("ovf_post_flag", bus.overflow, 0);

    // Reset mid-frame: partial word lost, a beat during reset ignored.
    beat(64'h31, 1'b0);
    beat(64'h32, 1'b0);
    rst = 1'b1;
    beat(64'h33, 1'b0);
    idle(1);
    chk_zero("midrst");
    rst = 1'b0;
    idle(3);
    chk("midrst_nowr", bus.wr_en, 0);
    expect_word(mkword(64'h41, 64'h42, 64'h43, 64'h44), 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) beat(W'(32'h41 + i), 1'b0);
    idle(5);
    chk("final_drop", bus.drop_cnt, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
